// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared decomposed-instruction layout and tag width.
//  Revision    : 1.0  initial release
// ============================================================================
package core_pkg;

    localparam int TAG_W    = 5;
    localparam int INST_W   = 117;
    localparam int VT_W     = 32;

    // {memdata[32], ctrl[14], rs2_vt[32], s2_valid, rs1_vt[32], s1_valid, rd[5]}
    localparam int RD_LSB   = 0;
    localparam int S1V_BIT  = 5;
    localparam int RS1_LSB  = 6;
    localparam int S2V_BIT  = 38;
    localparam int RS2_LSB  = 39;
    localparam int CTRL_LSB = 71;
    localparam int MEM_LSB  = 85;

endpackage
`default_nettype wire

// File: rtl/rs_pick_oldest.sv
`default_nettype none
// ============================================================================
//  Module      : rs_pick_oldest
//  Description : Lowest-index-wins picker: ready vector to one-hot grant + index.
//  Revision    : 1.0  initial release
// ============================================================================
module rs_pick_oldest #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_ready,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = |i_ready;
        // Scan from the top so the lowest ready index is written last.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_ready[i]) begin
                o_grant = N'(1) << i;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dispatch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : dispatch_scheduler
//  Description : Collapsing reservation station; captures CDB results and
//                issues the oldest fully-ready entry to the ALU.
//  Revision    : 1.0  initial release
// ============================================================================
module dispatch_scheduler
    import core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [INST_W-1:0]            in_inst,
    output logic                         in_ready,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [VT_W-1:0]              cdb_value,
    output logic                         issue_valid,
    output logic [INST_W-1:0]            issue_inst,
    input  logic                         issue_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [INST_W-1:0] r_entry [DEPTH];
    logic [CNT_W-1:0]  r_count;

    // Index DEPTH of these arrays is the incoming instruction.
    logic [INST_W-1:0] w_src   [DEPTH+1];
    logic [INST_W-1:0] w_woken [DEPTH+1];
    logic [INST_W-1:0] w_next  [DEPTH];

    logic [DEPTH-1:0]  w_ready;
    logic [DEPTH-1:0]  w_grant;
    logic [IDX_W-1:0]  w_idx;
    logic              w_any;
    logic              w_fire_issue;
    logic              w_fire_alloc;
    logic [CNT_W-1:0]  w_alloc_slot;

    generate
        for (genvar i = 0; i <= DEPTH; i++) begin : g_wake
            logic w_hit1;
            logic w_hit2;

            if (i < DEPTH) begin : g_ent
                assign w_src[i] = r_entry[i];
            end else begin : g_in
                assign w_src[i] = in_inst;
            end

            assign w_hit1 = cdb_valid & ~w_src[i][S1V_BIT]
                          & (w_src[i][RS1_LSB +: TAG_W] == cdb_tag);
            assign w_hit2 = cdb_valid & ~w_src[i][S2V_BIT]
                          & (w_src[i][RS2_LSB +: TAG_W] == cdb_tag);

            assign w_woken[i] = {
                w_src[i][INST_W-1:RS2_LSB+VT_W],
                w_hit2 ? cdb_value : w_src[i][RS2_LSB +: VT_W],
                w_src[i][S2V_BIT] | w_hit2,
                w_hit1 ? cdb_value : w_src[i][RS1_LSB +: VT_W],
                w_src[i][S1V_BIT] | w_hit1,
                w_src[i][S1V_BIT-1:RD_LSB]
            };
        end
    endgenerate

    rs_pick_oldest #(
        .N      (DEPTH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .i_ready (w_ready),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign full         = (r_count == CNT_W'(DEPTH));
    assign empty        = (r_count == '0);
    assign in_ready     = ~full;
    assign count        = r_count;
    assign issue_valid  = w_any;
    assign w_fire_issue = w_any & issue_ready;
    assign w_fire_alloc = in_valid & in_ready;
    assign w_alloc_slot = w_fire_issue ? (r_count - CNT_W'(1)) : r_count;

    always_comb begin
        issue_inst = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_grant[i]) begin
                issue_inst = issue_inst | r_entry[i];
            end
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_slot
            logic [INST_W-1:0] w_kept;

            assign w_ready[i] = (CNT_W'(i) < r_count)
                              & r_entry[i][S1V_BIT] & r_entry[i][S2V_BIT];

            // Slots at or above the issued one pull the (woken) entry from above.
            if (i < DEPTH - 1) begin : g_shift
                assign w_kept = (w_fire_issue && (CNT_W'(i) >= CNT_W'(w_idx)))
                              ? w_woken[i+1] : w_woken[i];
            end else begin : g_top
                assign w_kept = w_woken[i];
            end

            assign w_next[i] = (w_fire_alloc && (w_alloc_slot == CNT_W'(i)))
                             ? w_woken[DEPTH] : w_kept;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
        end else begin
            r_count <= r_count + CNT_W'(w_fire_alloc) - CNT_W'(w_fire_issue);
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= w_next[i];
            end
        end
    end

endmodule
`default_nettype wire
